pci_io_cfg: RTL and testbench
=============================

// Module: pci_io_cfg
// PURPOSE
//  PCI target I/O support block: fixed config-header ROM (vendor/device, class/revision words), the
//  PCI clock-enable term, and the bank of preset-on-reset output flops that drive the PCI pads.
//  Sits between the PCI target state machine (next-cycle D values) and the tri-state pad buffers.
//  Every pad output and output-enable is registered and preset to 1 (deasserted/high-Z) by RST.
// PARAMETERS
//  VENDOR_ID   16'h10EE    config word 0 [15:0]
//  DEVICE_ID   16'h0001    config word 0 [31:16]
//  CLASS_CODE  24'hFF0000  config word 2 [31:8]
//  REVISION_ID 8'h01       config word 2 [7:0]
// PORTS
//  CLK             in   1   PCI clock; all flops rise on posedge
//  RST             in   1   async active-high reset; presets every registered output to 1
//  IRDY, TRDY      in   1   raw IRDY#/TRDY# levels (low = asserted) for CE term
//  I1, I2, I3      in   1   CE qualifiers (PCI usage: I1=0, I2=0, I3=1)
//  PCI_CE          out  1   combinational clock enable
//  CFG_VENDOR      out  32  {DEVICE_ID, VENDOR_ID}, constant
//  CFG_CC_REVISION out  32  {CLASS_CODE, REVISION_ID}, constant
//  AD_D            in   32  next AD value;      AD_O        out 32 registered
//  OE_AD_D_N       in   1   next AD enable;     OE_AD_N     out 1  registered (0 = drive)
//  PAR_D           in   1   next PAR;           PAR_O       out 1  registered
//  OE_PAR_D_N      in   1                       OE_PAR_N    out 1  registered
//  CBE_D_N         in   4                       CBE_O_N     out 4  registered
//  OE_CBE_D_N      in   1                       OE_CBE_N    out 1  registered
//  TRDY_D_N        in   1                       TRDY_O_N    out 1  registered
//  OE_TRDY_D_N     in   1                       OE_TRDY_N   out 1  registered
//  DEVSEL_D_N      in   1                       DEVSEL_O_N  out 1  registered
//  OE_DEVSEL_D_N   in   1                       OE_DEVSEL_N out 1  registered
//  PAR_CALC        out  1   combinational ^{AD_D, CBE_D_N} (even parity over 36 bits)
// BEHAVIOUR
//  - PCI_CE = I2 | ~(I3 | TRDY) | ~(I1 | IRDY); purely combinational, no reset dependency.
//  - Config words are constants from parameters; unaffected by CLK/RST.
//  - Output bank: 44 single-bit flops (32 AD, 4 CBE, PAR, TRDY, DEVSEL, 5 OE). Per bit:
//    RST=1 -> Q=1 immediately (async, no clock); else Q <= D on posedge CLK. CE tied high.
//  - Latency D->Q exactly 1 clock for every bit; no cross-bit coupling or gating.
//  - Reset values: AD_O=32'hFFFFFFFF, CBE_O_N=4'hF, PAR_O=1, TRDY_O_N=1, DEVSEL_O_N=1,
//    all OE_*_N=1 (pads high-Z).
//  - RST asserted mid-operation: outputs go to 1 within the same cycle regardless of D/CLK.
//    RST deasserting: first posedge with RST=0 loads D (no extra sync stage inside).
//  - RST high on a clock edge: preset wins over D.
//  - PAR_CALC is formed from the D inputs; the state machine feeds it back as PAR_D one cycle
//    later (PCI parity lags data by one clock). PAR_CALC itself has no register.
//  - No X propagation: D inputs of X leave Q undefined only until the next valid load.
// STRUCTURE
//  - Package pci_io_pkg: default ID/class constants, CFG word indices (VENDOR=0, CMD_STAT=1,
//    CC_REV=2, INTR=15), AD width 32, CBE width 4.
//  - Sub-module pci_pff: one-bit D flop, async active-high preset, ports C, D, PRE, Q;
//    instantiated 44 times via generate. CE logic and ROM stay inline.
// TESTING
//  - RST=1 with random D, no clock -> all 44 outputs =1; release RST, D=AD 32'h12345678,
//    OE_AD_D_N=0 -> after 1 posedge AD_O=32'h12345678, OE_AD_N=0.
//  - CE truth table: I1=0,I2=0,I3=1: IRDY=0 -> PCI_CE=1; IRDY=1,TRDY=x -> 0; I2=1 -> 1 always;
//    I3=0, TRDY=0, IRDY=1 -> 1.
//  - Read CFG_VENDOR=32'h000110EE, CFG_CC_REVISION=32'hFF000001 with defaults; override
//    VENDOR_ID=16'hABCD -> CFG_VENDOR[15:0]=16'hABCD.
//  - PAR_CALC: AD_D=32'h00000001, CBE_D_N=4'h0 -> 1; AD_D=32'h00000003, CBE_D_N=4'h1 -> 1;
//    AD_D=0, CBE_D_N=4'hF -> 0.
//  - Mid-burst reset: toggle DEVSEL_D_N/TRDY_D_N=0 for 3 clocks, assert RST between edges ->
//    DEVSEL_O_N, TRDY_O_N, OE_* go 1 before next edge and stay 1 while RST=1.
//  - Pipeline: D stream of 8 incrementing AD values -> AD_O reproduces it delayed exactly 1 clock.

Source files
------------

// File: rtl/pci_io_pkg.sv
// Shared constants for the PCI target I/O support block: default IDs, config word
// indices, bus widths and the parity helper.
package pci_io_pkg;

  localparam int AD_W     = 32;
  localparam int CBE_W    = 4;
  localparam int FF_COUNT = AD_W + CBE_W + 8;

  localparam logic [15:0] DEF_VENDOR_ID   = 16'h10EE;
  localparam logic [15:0] DEF_DEVICE_ID   = 16'h0001;
  localparam logic [23:0] DEF_CLASS_CODE  = 24'hFF0000;
  localparam logic [7:0]  DEF_REVISION_ID = 8'h01;

  typedef enum logic [3:0] {
    CFG_IDX_VENDOR   = 4'd0,
    CFG_IDX_CMD_STAT = 4'd1,
    CFG_IDX_CC_REV   = 4'd2,
    CFG_IDX_INTR     = 4'd15
  } cfg_idx_e;

  // Even parity over address/data plus command/byte-enables.
  function automatic logic par36(input logic [AD_W-1:0] ad, input logic [CBE_W-1:0] cbe);
    return ^{ad, cbe};
  endfunction

endpackage

// File: rtl/pci_io_cfg_if.sv
// Bundle between the PCI target state machine (master) and the pad/config block (slave).
interface pci_io_cfg_if;
  import pci_io_pkg::*;

  logic             IRDY, TRDY, I1, I2, I3, PCI_CE;
  logic [31:0]      CFG_VENDOR, CFG_CC_REVISION;
  logic [AD_W-1:0]  AD_D, AD_O;
  logic [CBE_W-1:0] CBE_D_N, CBE_O_N;
  logic             OE_AD_D_N, OE_AD_N, PAR_D, PAR_O, OE_PAR_D_N, OE_PAR_N;
  logic             OE_CBE_D_N, OE_CBE_N, TRDY_D_N, TRDY_O_N, OE_TRDY_D_N, OE_TRDY_N;
  logic             DEVSEL_D_N, DEVSEL_O_N, OE_DEVSEL_D_N, OE_DEVSEL_N, PAR_CALC;

  modport master (
    output IRDY, TRDY, I1, I2, I3, AD_D, CBE_D_N, OE_AD_D_N, PAR_D, OE_PAR_D_N,
           OE_CBE_D_N, TRDY_D_N, OE_TRDY_D_N, DEVSEL_D_N, OE_DEVSEL_D_N,
    input  PCI_CE, CFG_VENDOR, CFG_CC_REVISION, AD_O, CBE_O_N, OE_AD_N, PAR_O, OE_PAR_N,
           OE_CBE_N, TRDY_O_N, OE_TRDY_N, DEVSEL_O_N, OE_DEVSEL_N, PAR_CALC
  );

  modport slave (
    input  IRDY, TRDY, I1, I2, I3, AD_D, CBE_D_N, OE_AD_D_N, PAR_D, OE_PAR_D_N,
           OE_CBE_D_N, TRDY_D_N, OE_TRDY_D_N, DEVSEL_D_N, OE_DEVSEL_D_N,
    output PCI_CE, CFG_VENDOR, CFG_CC_REVISION, AD_O, CBE_O_N, OE_AD_N, PAR_O, OE_PAR_N,
           OE_CBE_N, TRDY_O_N, OE_TRDY_N, DEVSEL_O_N, OE_DEVSEL_N, PAR_CALC
  );

endinterface

// File: rtl/pci_pff.sv
// One-bit pad flop with asynchronous active-high preset; idles at 1 so pads start high-Z.
module pci_pff (
  input  logic C,
  input  logic D,
  input  logic PRE,
  output logic Q
);

  // NOTE: sequential state uses non-blocking assignment so all 44 pad flops update together.
  always_ff @(posedge C or posedge PRE) begin
    if (PRE) Q <= 1'b1;
    else     Q <= D;
  end

endmodule

// File: rtl/pci_io_cfg.sv
// PCI target I/O support: config-header ROM, clock-enable term, parity generator and
// the preset-on-reset register bank in front of the tri-state pad buffers.
module pci_io_cfg
  import pci_io_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID   = DEF_VENDOR_ID,
  parameter logic [15:0] DEVICE_ID   = DEF_DEVICE_ID,
  parameter logic [23:0] CLASS_CODE  = DEF_CLASS_CODE,
  parameter logic [7:0]  REVISION_ID = DEF_REVISION_ID
) (
  input logic         CLK,
  input logic         RST,
  pci_io_cfg_if.slave bus
);

  logic [FF_COUNT-1:0] w_d;
  logic [FF_COUNT-1:0] w_q;

  function automatic logic [31:0] cfg_word(input cfg_idx_e idx);
    case (idx)
      CFG_IDX_VENDOR: return {DEVICE_ID, VENDOR_ID};
      CFG_IDX_CC_REV: return {CLASS_CODE, REVISION_ID};
      default:        return 32'h0;
    endcase
  endfunction

  assign bus.CFG_VENDOR      = cfg_word(CFG_IDX_VENDOR);
  assign bus.CFG_CC_REVISION = cfg_word(CFG_IDX_CC_REV);

  assign bus.PCI_CE   = bus.I2 | ~(bus.I3 | bus.TRDY) | ~(bus.I1 | bus.IRDY);
  assign bus.PAR_CALC = par36(bus.AD_D, bus.CBE_D_N);

  // Flatten every pad term into one vector so a single generate loop builds the bank.
  assign w_d = {bus.OE_DEVSEL_D_N, bus.DEVSEL_D_N, bus.OE_TRDY_D_N, bus.TRDY_D_N,
                bus.OE_CBE_D_N, bus.OE_PAR_D_N, bus.PAR_D, bus.OE_AD_D_N,
                bus.CBE_D_N, bus.AD_D};

  for (genvar g = 0; g < FF_COUNT; g++) begin : g_pff
    pci_pff u_pff (
      .C  (CLK),
      .D  (w_d[g]),
      .PRE(RST),
      .Q  (w_q[g])
    );
  end

  assign {bus.OE_DEVSEL_N, bus.DEVSEL_O_N, bus.OE_TRDY_N, bus.TRDY_O_N,
          bus.OE_CBE_N, bus.OE_PAR_N, bus.PAR_O, bus.OE_AD_N,
          bus.CBE_O_N, bus.AD_O} = w_q;

endmodule

// File: tb/tb_pci_io_cfg.sv
// Self-checking bench for pci_io_cfg: literal pin checks plus a randomized run against
// a behavioural model of the pad register bank, CE term and parity.
module tb_pci_io_cfg;
  import pci_io_pkg::*;

  typedef struct packed {
    logic [31:0] ad;
    logic [3:0]  cbe;
    logic        par, oe_ad, oe_par, oe_cbe, trdy, oe_trdy, devsel, oe_devsel;
  } bank_t;

  logic  CLK = 1'b0;
  logic  RST;
  bit    clk_run = 1'b0;
  bit    cmp_en  = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;
  bank_t cur_d;
  bank_t exp_q = '1;

  pci_io_cfg_if bus_a ();
  pci_io_cfg_if bus_b ();

  pci_io_cfg dut (.CLK(CLK), .RST(RST), .bus(bus_a.slave));
  pci_io_cfg #(.VENDOR_ID(16'hABCD)) dut_ovr (.CLK(CLK), .RST(RST), .bus(bus_b.slave));

  always begin
    #5;
    if (clk_run) CLK = ~CLK;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bank_t d);
    cur_d = d;
    bus_a.AD_D = d.ad;            bus_a.CBE_D_N = d.cbe;
    bus_a.PAR_D = d.par;          bus_a.OE_AD_D_N = d.oe_ad;
    bus_a.OE_PAR_D_N = d.oe_par;  bus_a.OE_CBE_D_N = d.oe_cbe;
    bus_a.TRDY_D_N = d.trdy;      bus_a.OE_TRDY_D_N = d.oe_trdy;
    bus_a.DEVSEL_D_N = d.devsel;  bus_a.OE_DEVSEL_D_N = d.oe_devsel;
  endtask

  task automatic set_ce(input logic i1, i2, i3, irdy, trdy);
    bus_a.I1 = i1; bus_a.I2 = i2; bus_a.I3 = i3; bus_a.IRDY = irdy; bus_a.TRDY = trdy;
  endtask

  function automatic bank_t rand_bank();
    bank_t b;
    logic [7:0] r;
    r = 8'($urandom);
    b.ad = $urandom;
    b.cbe = 4'($urandom);
    {b.par, b.oe_ad, b.oe_par, b.oe_cbe, b.trdy, b.oe_trdy, b.devsel, b.oe_devsel} = r;
    return b;
  endfunction

  function automatic bank_t dut_q();
    bank_t b;
    b.ad = bus_a.AD_O;            b.cbe = bus_a.CBE_O_N;
    b.par = bus_a.PAR_O;          b.oe_ad = bus_a.OE_AD_N;
    b.oe_par = bus_a.OE_PAR_N;    b.oe_cbe = bus_a.OE_CBE_N;
    b.trdy = bus_a.TRDY_O_N;      b.oe_trdy = bus_a.OE_TRDY_N;
    b.devsel = bus_a.DEVSEL_O_N;  b.oe_devsel = bus_a.OE_DEVSEL_N;
    return b;
  endfunction

  // Clock enable is active when any qualifier path permits it.
  function automatic logic ce_model(input logic i1, i2, i3, irdy, trdy);
    if (i2) return 1'b1;
    if (!i3 && !trdy) return 1'b1;
    if (!i1 && !irdy) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic par_model(input logic [31:0] ad, input logic [3:0] cbe);
    return ($countones(ad) + $countones(cbe)) % 2 == 1;
  endfunction

  // Model: pads show the D values of the previous edge, or all ones under reset.
  always @(posedge CLK or posedge RST) begin
    if (RST) exp_q <= '1;
    else     exp_q <= cur_d;
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      bank_t a;
      a = dut_q();
      check("ad_o", a.ad, exp_q.ad);
      check("cbe_o_n", a.cbe, exp_q.cbe);
      check("ctl_oe_bank", a[7:0], exp_q[7:0]);
    end
  end

  task automatic comb_check();
    #1;
    check("pci_ce", bus_a.PCI_CE, ce_model(bus_a.I1, bus_a.I2, bus_a.I3, bus_a.IRDY, bus_a.TRDY));
    check("par_calc", bus_a.PAR_CALC, par_model(bus_a.AD_D, bus_a.CBE_D_N));
  endtask

  initial begin
    bank_t d;
    logic [31:0] base;
    int r;

    RST = 1'b0;
    apply('0);
    set_ce(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    bus_b.AD_D = '0; bus_b.CBE_D_N = '0; bus_b.PAR_D = 1'b0; bus_b.OE_AD_D_N = 1'b0;
    bus_b.OE_PAR_D_N = 1'b0; bus_b.OE_CBE_D_N = 1'b0; bus_b.TRDY_D_N = 1'b0;
    bus_b.OE_TRDY_D_N = 1'b0; bus_b.DEVSEL_D_N = 1'b0; bus_b.OE_DEVSEL_D_N = 1'b0;
    bus_b.I1 = 1'b0; bus_b.I2 = 1'b0; bus_b.I3 = 1'b1; bus_b.IRDY = 1'b0; bus_b.TRDY = 1'b0;

    // Reset with random D and no clock running.
    #1 RST = 1'b1;
    apply(rand_bank());
    #3;
    check("rst_ad_o", bus_a.AD_O, 32'hFFFFFFFF);
    check("rst_cbe_o_n", bus_a.CBE_O_N, 4'hF);
    check("rst_par_trdy_devsel", {bus_a.PAR_O, bus_a.TRDY_O_N, bus_a.DEVSEL_O_N}, 3'b111);
    check("rst_oe_all", {bus_a.OE_AD_N, bus_a.OE_PAR_N, bus_a.OE_CBE_N,
                         bus_a.OE_TRDY_N, bus_a.OE_DEVSEL_N}, 5'b11111);

    check("cfg_vendor", bus_a.CFG_VENDOR, 32'h000110EE);
    check("cfg_cc_rev", bus_a.CFG_CC_REVISION, 32'hFF000001);
    check("cfg_vendor_ovr_lo", bus_b.CFG_VENDOR[15:0], 16'hABCD);
    check("cfg_vendor_ovr_hi", bus_b.CFG_VENDOR[31:16], 16'h0001);

    d = '1; d.ad = 32'h00000001; d.cbe = 4'h0; apply(d); #1;
    check("par_lit_1", bus_a.PAR_CALC, 1'b1);
    d.ad = 32'h00000003; d.cbe = 4'h1; apply(d); #1;
    check("par_lit_2", bus_a.PAR_CALC, 1'b1);
    d.ad = 32'h00000000; d.cbe = 4'hF; apply(d); #1;
    check("par_lit_3", bus_a.PAR_CALC, 1'b0);

    set_ce(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); #1 check("ce_irdy_low", bus_a.PCI_CE, 1'b1);
    set_ce(1'b0, 1'b0, 1'b1, 1'b1, 1'b0); #1 check("ce_irdy_high_t0", bus_a.PCI_CE, 1'b0);
    set_ce(1'b0, 1'b0, 1'b1, 1'b1, 1'b1); #1 check("ce_irdy_high_t1", bus_a.PCI_CE, 1'b0);
    set_ce(1'b0, 1'b1, 1'b1, 1'b1, 1'b1); #1 check("ce_i2_force", bus_a.PCI_CE, 1'b1);
    set_ce(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1 check("ce_i3_trdy", bus_a.PCI_CE, 1'b1);

    // Release reset: first edge loads D.
    clk_run = 1'b1;
    @(negedge CLK);
    d = rand_bank(); d.ad = 32'h12345678; d.oe_ad = 1'b0; apply(d);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("first_load_ad", bus_a.AD_O, 32'h12345678);
    check("first_load_oe_ad", bus_a.OE_AD_N, 1'b0);
    cmp_en = 1'b1;

    // Pipeline of incrementing AD values.
    base = 32'hA5A50000;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i > 0) check("pipe_ad", bus_a.AD_O, base + 32'(i - 1));
      d.ad = base + 32'(i); apply(d);
    end
    @(negedge CLK);
    check("pipe_ad_last", bus_a.AD_O, base + 32'd7);

    // Mid-burst reset between edges.
    d = '0; d.devsel = 1'b0; d.trdy = 1'b0; apply(d);
    repeat (3) @(posedge CLK);
    #1 check("burst_devsel_driven", {bus_a.DEVSEL_O_N, bus_a.TRDY_O_N}, 2'b00);
    #2 RST = 1'b1;
    #1 check("burst_rst_async", {bus_a.DEVSEL_O_N, bus_a.TRDY_O_N, bus_a.OE_AD_N, bus_a.OE_PAR_N,
                                 bus_a.OE_CBE_N, bus_a.OE_TRDY_N, bus_a.OE_DEVSEL_N}, 7'h7F);
    @(posedge CLK); #1;
    check("burst_rst_hold", {bus_a.DEVSEL_O_N, bus_a.TRDY_O_N, bus_a.OE_TRDY_N,
                             bus_a.OE_DEVSEL_N}, 4'hF);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    check("burst_release", {bus_a.DEVSEL_O_N, bus_a.TRDY_O_N}, 2'b00);

    // Randomized run with occasional asynchronous resets.
    repeat (300) begin
      @(negedge CLK);
      apply(rand_bank());
      set_ce(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      comb_check();
      r = $urandom_range(0, 15);
      if (RST && r < 6) begin
        RST = 1'b0;
      end else if (!RST && r == 0) begin
        #2 RST = 1'b1;
        #1 check("rand_rst_ad", bus_a.AD_O, 32'hFFFFFFFF);
      end
    end
    @(negedge CLK) RST = 1'b0;
    repeat (2) @(negedge CLK);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
